// File: rtl/key_debounce_multi.sv
// N-channel key conditioner: 2-FF sync, stable-count debounce, press/release/long strobes, toggle.
// Latency 2+DEBOUNCE_CYC cycles pin-to-strobe; no backpressure, strobes are single-cycle and unbuffered.
module key_debounce_multi #(
    parameter int   NUM_KEYS     = 4,
    parameter int   DEBOUNCE_CYC = 1000000,
    parameter int   LONG_CYC     = 50000000,
    parameter int   ACTIVE_LOW   = 1,
    parameter logic TOGGLE_INIT  = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rstn,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] rel_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] toggle_out,
    output logic                any_press
);

    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int LW = $clog2(LONG_CYC + 1);

    localparam logic          REL_LVL = (ACTIVE_LOW != 0);
    localparam logic [DW-1:0] DMAX    = DW'(DEBOUNCE_CYC - 1);
    localparam logic [LW-1:0] LMAX    = LW'(LONG_CYC);
    localparam logic [LW-1:0] LPRE    = LW'(LONG_CYC - 1);

    logic [NUM_KEYS-1:0] s1_q, s1_d;
    logic [NUM_KEYS-1:0] s2_q, s2_d;
    logic [NUM_KEYS-1:0] p;
    logic [NUM_KEYS-1:0] state_q, state_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] rel_q, rel_d;
    logic [NUM_KEYS-1:0] long_q, long_d;
    logic [NUM_KEYS-1:0] toggle_q, toggle_d;
    logic                any_q, any_d;
    logic [DW-1:0]       dcnt_q [NUM_KEYS];
    logic [DW-1:0]       dcnt_d [NUM_KEYS];
    logic [LW-1:0]       lcnt_q [NUM_KEYS];
    logic [LW-1:0]       lcnt_d [NUM_KEYS];

    always_comb begin
        s1_d    = key_in;
        s2_d    = s1_q;
        p       = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;
        state_d = state_q;
        press_d = '0;
        rel_d   = '0;
        long_d  = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            dcnt_d[i] = dcnt_q[i];
            lcnt_d[i] = lcnt_q[i];

            // Any sample matching the accepted level restarts the stability count.
            if (p[i] == state_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DMAX) begin
                dcnt_d[i]  = '0;
                state_d[i] = p[i];
                press_d[i] = p[i];
                rel_d[i]   = ~p[i];
            end else begin
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            end

            // Long-press counter saturates so the strobe fires once per press.
            if (!state_q[i]) begin
                lcnt_d[i] = '0;
            end else if (lcnt_q[i] != LMAX) begin
                lcnt_d[i] = lcnt_q[i] + LW'(1);
            end
            long_d[i] = state_q[i] && (lcnt_q[i] == LPRE);
        end
        toggle_d = toggle_q ^ press_d;
        any_d    = |press_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            s1_q     <= {NUM_KEYS{REL_LVL}};
            s2_q     <= {NUM_KEYS{REL_LVL}};
            state_q  <= '0;
            press_q  <= '0;
            rel_q    <= '0;
            long_q   <= '0;
            toggle_q <= {NUM_KEYS{TOGGLE_INIT}};
            any_q    <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                dcnt_q[i] <= '0;
                lcnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            state_q  <= state_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            long_q   <= long_d;
            toggle_q <= toggle_d;
            any_q    <= any_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                lcnt_q[i] <= lcnt_d[i];
            end
        end
    end

    assign key_state   = state_q;
    assign press_pulse = press_q;
    assign rel_pulse   = rel_q;
    assign long_pulse  = long_q;
    assign toggle_out  = toggle_q;
    assign any_press   = any_q;

endmodule
